riscv_alu_sequencer_pipelined: RTL and testbench

- Issue/writeback sequencer for the execute stage. Replaces the combinational per-unit result select and stall-count scheme.
- Accepts one ALU operation per handshake and classifies it as integer (I), multiply (MUL), divide (DIV) or float (FPU).
- Issues a one-hot strobe to the selected fixed-latency unit, counts its latency, and captures the unit result.
- Presents the result on a registered valid/ready response port. Supports flush and reports remaining busy cycles to the hazard unit.

---
 rtl/riscv_alu_sequencer_pipelined.sv | 194 +++++++++++++++++++
 tb/tb_riscv_alu_sequencer_pipelined.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_sequencer_pipelined.sv
// rtl/riscv_alu_sequencer_pipelined.sv - execute-stage issue/writeback sequencer for fixed-latency ALU units
module riscv_alu_sequencer_pipelined #(
  parameter int unsigned RV32M      = 0,
  parameter int unsigned RV32F      = 0,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned DIV_STAGES = 8,
  parameter int unsigned FPU_STAGES = 4,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_class_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [3:0]       issue_o,
  input  logic [31:0]      i_result_i,
  input  logic [31:0]      mul_result_i,
  input  logic [31:0]      div_result_i,
  input  logic [31:0]      fpu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_illegal_o,
  output logic [4:0]       stall_cycles_o
);

  localparam logic [1:0] CLS_I   = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;
  localparam logic [1:0] CLS_DIV = 2'd2;
  localparam logic [1:0] CLS_FPU = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [1:0]       cls_q, cls_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             start;
  logic             req_legal;
  logic [4:0]       req_lat;

  // A class is only legal if its unit is built into this configuration.
  function automatic logic cls_legal(input logic [1:0] c);
    logic ok;
    case (c)
      CLS_I:            ok = 1'b1;
      CLS_MUL, CLS_DIV: ok = (RV32M != 0);
      default:          ok = (RV32F != 0);
    endcase
    return ok;
  endfunction

  // Cycles from accept to response; illegal ops complete like an integer op.
  function automatic logic [4:0] cls_lat(input logic [1:0] c, input logic legal);
    logic [4:0] l;
    if (!legal) begin
      l = 5'd1;
    end else begin
      case (c)
        CLS_MUL: l = 5'(MUL_STAGES);
        CLS_DIV: l = 5'(DIV_STAGES);
        CLS_FPU: l = 5'(FPU_STAGES);
        default: l = 5'd1;
      endcase
    end
    return l;
  endfunction

  // Result mux by class.
  function automatic logic [31:0] pick(input logic [1:0] c, input logic [31:0] ri,
                                       input logic [31:0] rm, input logic [31:0] rd,
                                       input logic [31:0] rf);
    logic [31:0] r;
    case (c)
      CLS_MUL: r = rm;
      CLS_DIV: r = rd;
      CLS_FPU: r = rf;
      default: r = ri;
    endcase
    return r;
  endfunction

  assign req_legal = cls_legal(req_class_i);
  assign req_lat   = cls_lat(req_class_i, req_legal);

  // Ready is held low during reset and flush so nothing is accepted then.
  assign req_ready_o = resetn_i && !flush_i &&
                       ((state_q == IDLE) || ((state_q == DONE) && rsp_ready_i));
  assign accept      = req_valid_i && req_ready_o;

  // Start strobe only for real external units; the integer result is already here.
  always_comb begin
    issue_o = 4'b0000;
    if (accept && req_legal && (req_class_i != CLS_I)) begin
      issue_o[req_class_i] = 1'b1;
    end
  end

  assign rsp_valid_o    = (state_q == DONE);
  assign rsp_data_o     = data_q;
  assign rsp_tag_o      = tag_q;
  assign rsp_illegal_o  = illegal_q;
  assign stall_cycles_o = (state_q == BUSY) ? cnt_q : 5'd0;

  // Next-state and datapath capture; flush overrides every other transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cls_d     = cls_q;
    tag_d     = tag_q;
    data_d    = data_q;
    illegal_d = illegal_q;
    start     = 1'b0;

    case (state_q)
      IDLE: begin
        start = accept;
      end
      BUSY: begin
        if (cnt_q == 5'd1) begin
          data_d  = pick(cls_q, i_result_i, mul_result_i, div_result_i, fpu_result_i);
          cnt_d   = 5'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          start   = accept;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    // A new op may start from IDLE or straight out of DONE without a bubble.
    if (start) begin
      cls_d     = req_class_i;
      tag_d     = req_tag_i;
      illegal_d = !req_legal;
      if (req_lat == 5'd1) begin
        data_d  = req_legal ? pick(req_class_i, i_result_i, mul_result_i, div_result_i,
                                   fpu_result_i) : 32'd0;
        cnt_d   = 5'd0;
        state_d = DONE;
      end else begin
        cnt_d   = req_lat - 5'd1;
        state_d = BUSY;
      end
    end

    if (flush_i) begin
      state_d   = IDLE;
      cnt_d     = 5'd0;
      data_d    = 32'd0;
      illegal_d = 1'b0;
    end
  end

  // State and captured response registers.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      cls_q     <= CLS_I;
      tag_q     <= '0;
      data_q    <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_riscv_alu_sequencer_pipelined.sv
// tb/tb_riscv_alu_sequencer_pipelined.sv - scoreboard bench for riscv_alu_sequencer_pipelined
module tb_riscv_alu_sequencer_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid, req_valid_b;
  logic [1:0]  req_class;
  logic [4:0]  req_tag;
  logic [31:0] i_res, mul_res, div_res, fpu_res;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, rsp_illegal;
  logic [3:0]  issue;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag, stall;

  logic        req_ready_b, rsp_valid_b, rsp_illegal_b;
  logic [3:0]  issue_b;
  logic [31:0] rsp_data_b;
  logic [4:0]  rsp_tag_b, stall_b;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  riscv_alu_sequencer_pipelined #(
    .RV32M(1), .RV32F(1), .MUL_STAGES(2), .DIV_STAGES(8), .FPU_STAGES(4), .TAG_W(5)
  ) dut (
    .clock_i(clk), .resetn_i(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_class_i(req_class),
    .req_tag_i(req_tag), .issue_o(issue), .i_result_i(i_res), .mul_result_i(mul_res),
    .div_result_i(div_res), .fpu_result_i(fpu_res), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_tag_o(rsp_tag),
    .rsp_illegal_o(rsp_illegal), .stall_cycles_o(stall)
  );

  riscv_alu_sequencer_pipelined #(.TAG_W(5)) dut_b (
    .clock_i(clk), .resetn_i(rst_n), .flush_i(flush),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_class_i(req_class),
    .req_tag_i(req_tag), .issue_o(issue_b), .i_result_i(i_res), .mul_result_i(mul_res),
    .div_result_i(div_res), .fpu_result_i(fpu_res), .rsp_valid_o(rsp_valid_b),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_b), .rsp_tag_o(rsp_tag_b),
    .rsp_illegal_o(rsp_illegal_b), .stall_cycles_o(stall_b)
  );

  // Response monitor: every completed handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && !flush && rsp_valid && rsp_ready) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got data=%h tag=%0d ill=%b, none expected",
                 rsp_data, rsp_tag, rsp_illegal);
      end else begin
        e = q.pop_front();
        if ({rsp_data, rsp_tag, rsp_illegal} !== e) begin
          bad++;
          $display("FAIL rsp_match: got data=%h tag=%0d ill=%b want data=%h tag=%0d ill=%b",
                   rsp_data, rsp_tag, rsp_illegal, e.data, e.tag, e.ill);
        end
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    smp;
    smp;
    total++;
    if ({req_ready, rsp_valid, issue, stall, rsp_data, rsp_tag, rsp_illegal} !== 45'd0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b iss=%b stall=%0d data=%h want all 0",
               req_ready, rsp_valid, issue, stall, rsp_data);
    end
    nxt;
    rst_n = 1'b1;
    smp;
    total++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release: rdy=%b vld=%b want rdy=1 vld=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_i_class;
    nxt;
    req_valid = 1'b1; req_class = 2'd0; req_tag = 5'd3; i_res = 32'h1234; rsp_ready = 1'b1;
    smp;
    total++;
    if ({req_ready, issue} !== 5'b1_0000) begin
      bad++;
      $display("FAIL i_accept: rdy=%b iss=%b want 1 0000", req_ready, issue);
    end
    q.push_back({32'h1234, 5'd3, 1'b0});
    for (int k = 0; k < 5; k++) begin
      nxt;
      req_tag = 5'(10 + k);
      i_res   = $urandom;
      smp;
      total++;
      if ({req_ready, rsp_valid, issue} !== 6'b11_0000) begin
        bad++;
        $display("FAIL i_b2b_%0d: rdy=%b vld=%b iss=%b want 1 1 0000", k, req_ready, rsp_valid, issue);
      end
      q.push_back({i_res, req_tag, 1'b0});
    end
    nxt;
    req_valid = 1'b0;
    smp;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL i_last_valid: got %b want 1", rsp_valid);
    end
    nxt;
    smp;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL i_drain: vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_div;
    nxt;
    req_valid = 1'b1; req_class = 2'd2; req_tag = 5'd7; rsp_ready = 1'b0; div_res = 32'hBAD0;
    smp;
    total++;
    if ({req_ready, issue} !== 5'b1_0100) begin
      bad++;
      $display("FAIL div_issue: rdy=%b iss=%b want 1 0100", req_ready, issue);
    end
    q.push_back({32'hDEAD, 5'd7, 1'b0});
    for (int c = 1; c <= 8; c++) begin
      nxt;
      req_class = 2'd0;
      div_res   = (c == 7) ? 32'hDEAD : 32'hBAD0;
      smp;
      total++;
      if (c < 8) begin
        if ({rsp_valid, req_ready, issue, stall} !== {1'b0, 1'b0, 4'b0, 5'(8 - c)}) begin
          bad++;
          $display("FAIL div_busy_c%0d: vld=%b rdy=%b iss=%b stall=%0d want 0 0 0000 %0d",
                   c, rsp_valid, req_ready, issue, stall, 8 - c);
        end
      end else begin
        if ({rsp_valid, req_ready, stall, rsp_data} !== {1'b1, 1'b0, 5'd0, 32'hDEAD}) begin
          bad++;
          $display("FAIL div_done: vld=%b rdy=%b stall=%0d data=%h want 1 0 0 dead",
                   rsp_valid, req_ready, stall, rsp_data);
        end
      end
    end
    nxt;
    req_valid = 1'b0; rsp_ready = 1'b1;
    smp;
    total++;
    if ({rsp_valid, req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL div_take: vld=%b rdy=%b want 1 1", rsp_valid, req_ready);
    end
    nxt;
    smp;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL div_idle: vld=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_mul_hold_then_fpu;
    nxt;
    req_valid = 1'b1; req_class = 2'd1; req_tag = 5'd5; rsp_ready = 1'b0; mul_res = 32'h1111;
    smp;
    total++;
    if ({req_ready, issue} !== 5'b1_0010) begin
      bad++;
      $display("FAIL mul_issue: rdy=%b iss=%b want 1 0010", req_ready, issue);
    end
    q.push_back({32'h1111, 5'd5, 1'b0});
    nxt;
    req_valid = 1'b0;
    smp;
    total++;
    if ({rsp_valid, stall} !== {1'b0, 5'd1}) begin
      bad++;
      $display("FAIL mul_busy: vld=%b stall=%0d want 0 1", rsp_valid, stall);
    end
    for (int h = 0; h < 5; h++) begin
      nxt;
      mul_res = $urandom;
      smp;
      total++;
      if ({rsp_valid, rsp_data, rsp_tag, req_ready} !== {1'b1, 32'h1111, 5'd5, 1'b0}) begin
        bad++;
        $display("FAIL mul_hold_%0d: vld=%b data=%h tag=%0d rdy=%b want 1 1111 5 0",
                 h, rsp_valid, rsp_data, rsp_tag, req_ready);
      end
    end
    nxt;
    rsp_ready = 1'b1; req_valid = 1'b1; req_class = 2'd3; req_tag = 5'd12; fpu_res = 32'hF00D;
    smp;
    total++;
    if ({req_ready, issue} !== 5'b1_1000) begin
      bad++;
      $display("FAIL fpu_b2b_issue: rdy=%b iss=%b want 1 1000", req_ready, issue);
    end
    q.push_back({32'hF00D, 5'd12, 1'b0});
    for (int c = 1; c <= 3; c++) begin
      nxt;
      req_valid = 1'b0;
      smp;
      total++;
      if ({rsp_valid, stall} !== {1'b0, 5'(4 - c)}) begin
        bad++;
        $display("FAIL fpu_busy_c%0d: vld=%b stall=%0d want 0 %0d", c, rsp_valid, stall, 4 - c);
      end
    end
    nxt;
    smp;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL fpu_done: vld=%b want 1", rsp_valid);
    end
    nxt;
    smp;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL fpu_idle: vld=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_flush;
    nxt;
    req_valid = 1'b1; req_class = 2'd3; req_tag = 5'd2; fpu_res = 32'hBEEF; rsp_ready = 1'b1;
    smp;
    total++;
    if (issue !== 4'b1000) begin
      bad++;
      $display("FAIL flush_fpu_issue: iss=%b want 1000", issue);
    end
    nxt;
    req_valid = 1'b0;
    nxt;
    nxt;
    flush = 1'b1; req_valid = 1'b1; req_class = 2'd0;
    smp;
    total++;
    if ({req_ready, issue, rsp_valid} !== 6'b0) begin
      bad++;
      $display("FAIL flush_cycle: rdy=%b iss=%b vld=%b want 0 0000 0", req_ready, issue, rsp_valid);
    end
    nxt;
    flush = 1'b0; req_tag = 5'd1; i_res = 32'h77;
    smp;
    total++;
    if ({req_ready, rsp_valid, stall} !== {1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL flush_idle: rdy=%b vld=%b stall=%0d want 1 0 0", req_ready, rsp_valid, stall);
    end
    q.push_back({32'h77, 5'd1, 1'b0});
    nxt;
    req_valid = 1'b0;
    smp;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL flush_next_op: vld=%b want 1", rsp_valid);
    end
    for (int c = 0; c < 6; c++) begin
      nxt;
      smp;
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_late_%0d: vld=%b want 0", c, rsp_valid);
      end
    end
  endtask

  task automatic test_illegal;
    nxt;
    req_valid_b = 1'b1; req_class = 2'd3; req_tag = 5'd9; i_res = 32'hCAFE; rsp_ready = 1'b1;
    smp;
    total++;
    if ({req_ready_b, issue_b} !== 5'b1_0000) begin
      bad++;
      $display("FAIL ill_fpu_accept: rdy=%b iss=%b want 1 0000", req_ready_b, issue_b);
    end
    nxt;
    req_class = 2'd1; req_tag = 5'd4;
    smp;
    total++;
    if ({rsp_valid_b, rsp_illegal_b, rsp_data_b, rsp_tag_b, issue_b} !==
        {1'b1, 1'b1, 32'd0, 5'd9, 4'b0}) begin
      bad++;
      $display("FAIL ill_fpu_rsp: vld=%b ill=%b data=%h tag=%0d iss=%b want 1 1 0 9 0000",
               rsp_valid_b, rsp_illegal_b, rsp_data_b, rsp_tag_b, issue_b);
    end
    nxt;
    req_valid_b = 1'b0;
    smp;
    total++;
    if ({rsp_valid_b, rsp_illegal_b, rsp_data_b, rsp_tag_b} !== {1'b1, 1'b1, 32'd0, 5'd4}) begin
      bad++;
      $display("FAIL ill_mul_rsp: vld=%b ill=%b data=%h tag=%0d want 1 1 0 4",
               rsp_valid_b, rsp_illegal_b, rsp_data_b, rsp_tag_b);
    end
    nxt;
    smp;
    total++;
    if (rsp_valid_b !== 1'b0) begin
      bad++;
      $display("FAIL ill_idle: vld=%b want 0", rsp_valid_b);
    end
  endtask

  task automatic test_reset_mid_div;
    nxt;
    req_valid = 1'b1; req_class = 2'd2; req_tag = 5'd6; rsp_ready = 1'b1;
    nxt;
    req_valid = 1'b0;
    nxt;
    smp;
    total++;
    if (stall !== 5'd6) begin
      bad++;
      $display("FAIL rst_div_stall: stall=%0d want 6", stall);
    end
    nxt;
    rst_n = 1'b0; req_valid = 1'b1;
    #1;
    total++;
    if ({req_ready, rsp_valid, issue, stall, rsp_data, rsp_tag, rsp_illegal} !== 45'd0) begin
      bad++;
      $display("FAIL rst_mid_div: rdy=%b vld=%b iss=%b stall=%0d data=%h want all 0",
               req_ready, rsp_valid, issue, stall, rsp_data);
    end
    smp;
    nxt;
    req_valid = 1'b0; rst_n = 1'b1;
    smp;
    total++;
    if ({req_ready, rsp_valid, stall} !== {1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL rst_release: rdy=%b vld=%b stall=%0d want 1 0 0", req_ready, rsp_valid, stall);
    end
    for (int c = 0; c < 10; c++) begin
      nxt;
      smp;
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_no_stale_%0d: vld=%b want 0", c, rsp_valid);
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: left=%0d want 0", q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0;
    req_class = 2'd0; req_tag = 5'd0; rsp_ready = 1'b0;
    i_res = 32'd0; mul_res = 32'd0; div_res = 32'd0; fpu_res = 32'd0;
    test_reset;
    test_i_class;
    test_div;
    test_mul_hold_then_fpu;
    test_flush;
    test_illegal;
    test_reset_mid_div;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
